// File: rtl/bfs_simple_engine.sv
// Breadth-first search over an adjacency-row graph held in external word memory.
// Latency: one memory round trip per degree word and per neighbour word, plus 1-2 cycles per node.
// Backpressure: one read outstanding; waits indefinitely for mem_valid; start ignored while busy.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, start_node_id      one-cycle start request and root node (sampled on accept)
//   done, busy                traversal status (done held until the next start)
//   mem_addr, mem_rd_en       byte read address with one-cycle read strobe
//   mem_data, mem_valid       read response
//   nodes_visited_count       nodes discovered including the root
//   edges_scanned_count       neighbour words read
//   incr_edge_pulse           one pulse per neighbour word read
//   current_node_processing   node whose row is being scanned, current_level its BFS level
//   last_discovered_node      most recent discovery, node_discovered_pulse one pulse per discovery
module bfs_simple_engine #(
    parameter int NUM_NODES     = 32,
    parameter int MAX_NEIGHBORS = 16,
    parameter int BASE_ADDR     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_node_id,
    output logic        done,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_data,
    input  logic        mem_valid,
    output logic [31:0] nodes_visited_count,
    output logic [31:0] edges_scanned_count,
    output logic        incr_edge_pulse,
    output logic [31:0] current_node_processing,
    output logic [31:0] current_level,
    output logic [31:0] last_discovered_node,
    output logic        node_discovered_pulse
);
    localparam int          IDW       = $clog2(NUM_NODES);
    localparam int          DGW       = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [31:0] ROW_BYTES = 32'((MAX_NEIGHBORS + 1) * 4);
    localparam logic [31:0] NODES_W   = 32'(NUM_NODES);
    localparam logic [IDW:0] PTR_ONE  = (IDW + 1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_DEQ, S_RD_DEG, S_WAIT_DEG, S_RD_NBR, S_WAIT_NBR, S_CHECK, S_FINISH
    } state_t;

    typedef struct packed {
        logic [31:0]    level;
        logic [IDW-1:0] parent;
    } node_info_t;

    state_t               state_q;
    logic [NUM_NODES-1:0] visited_q;
    node_info_t           node_info_q [NUM_NODES];
    logic [IDW-1:0]       fifo_q [NUM_NODES];
    // Every node is pushed at most once per traversal, so the pointers never wrap.
    logic [IDW:0]         wr_ptr_q, rd_ptr_q;
    logic [31:0]          root_q, nbr_q;
    logic [DGW-1:0]       deg_q, idx_q;

    logic        done_q, busy_q, rd_en_q, incr_q, disc_q;
    logic [31:0] addr_q, visited_cnt_q, edges_q, cur_node_q, cur_level_q, last_q;

    logic [31:0]    row_base;
    logic [IDW-1:0] root_id, nbr_id;
    logic           nbr_new;
    logic [DGW-1:0] deg_clamped;

    assign row_base    = 32'(BASE_ADDR) + cur_node_q * ROW_BYTES;
    assign root_id     = root_q[IDW-1:0];
    assign nbr_id      = nbr_q[IDW-1:0];
    // Range test first: nbr_id is only meaningful once nbr_q is known to be a legal ID.
    assign nbr_new     = (nbr_q < NODES_W) && !visited_q[nbr_id];
    assign deg_clamped = (mem_data > 32'(MAX_NEIGHBORS)) ? DGW'(MAX_NEIGHBORS) : mem_data[DGW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            visited_q <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                node_info_q[i] <= '0;
                fifo_q[i]      <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            root_q        <= '0;
            nbr_q         <= '0;
            deg_q         <= '0;
            idx_q         <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            incr_q        <= 1'b0;
            disc_q        <= 1'b0;
            addr_q        <= '0;
            visited_cnt_q <= '0;
            edges_q       <= '0;
            cur_node_q    <= '0;
            cur_level_q   <= '0;
            last_q        <= '0;
        end else begin
            // Strobes are high for exactly the cycle after the state that raises them.
            rd_en_q <= 1'b0;
            incr_q  <= 1'b0;
            disc_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        visited_cnt_q <= '0;
                        edges_q       <= '0;
                        root_q        <= start_node_id;
                        visited_q     <= '0;
                        wr_ptr_q      <= '0;
                        rd_ptr_q      <= '0;
                        state_q       <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (root_q >= NODES_W) begin
                        state_q <= S_FINISH;
                    end else begin
                        visited_q[root_id]          <= 1'b1;
                        node_info_q[root_id]        <= '{level: 32'd0, parent: root_id};
                        fifo_q[wr_ptr_q[IDW-1:0]]   <= root_id;
                        wr_ptr_q                    <= wr_ptr_q + PTR_ONE;
                        disc_q                      <= 1'b1;
                        last_q                      <= root_q;
                        visited_cnt_q               <= 32'd1;
                        state_q                     <= S_DEQ;
                    end
                end
                S_DEQ: begin
                    if (rd_ptr_q == wr_ptr_q) begin
                        state_q <= S_FINISH;
                    end else begin
                        cur_node_q  <= 32'(fifo_q[rd_ptr_q[IDW-1:0]]);
                        cur_level_q <= node_info_q[fifo_q[rd_ptr_q[IDW-1:0]]].level;
                        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
                        state_q     <= S_RD_DEG;
                    end
                end
                S_RD_DEG: begin
                    addr_q  <= row_base;
                    rd_en_q <= 1'b1;
                    state_q <= S_WAIT_DEG;
                end
                S_WAIT_DEG: begin
                    if (mem_valid) begin
                        deg_q   <= deg_clamped;
                        idx_q   <= '0;
                        state_q <= (deg_clamped == '0) ? S_DEQ : S_RD_NBR;
                    end
                end
                S_RD_NBR: begin
                    // Neighbour k (0-based) sits at word k+1 of the row.
                    addr_q  <= row_base + ((32'(idx_q) + 32'd1) << 2);
                    rd_en_q <= 1'b1;
                    state_q <= S_WAIT_NBR;
                end
                S_WAIT_NBR: begin
                    if (mem_valid) begin
                        nbr_q   <= mem_data;
                        edges_q <= edges_q + 32'd1;
                        incr_q  <= 1'b1;
                        idx_q   <= idx_q + DGW'(1);
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (nbr_new) begin
                        visited_q[nbr_id]        <= 1'b1;
                        node_info_q[nbr_id]      <= '{level: cur_level_q + 32'd1, parent: cur_node_q[IDW-1:0]};
                        fifo_q[wr_ptr_q[IDW-1:0]] <= nbr_id;
                        wr_ptr_q                 <= wr_ptr_q + PTR_ONE;
                        visited_cnt_q            <= visited_cnt_q + 32'd1;
                        disc_q                   <= 1'b1;
                        last_q                   <= nbr_q;
                    end
                    // idx_q already counts the neighbour just checked.
                    state_q <= (idx_q == deg_q) ? S_DEQ : S_RD_NBR;
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done                    = done_q;
    assign busy                    = busy_q;
    assign mem_addr                = addr_q;
    assign mem_rd_en               = rd_en_q;
    assign nodes_visited_count     = visited_cnt_q;
    assign edges_scanned_count     = edges_q;
    assign incr_edge_pulse         = incr_q;
    assign current_node_processing = cur_node_q;
    assign current_level           = cur_level_q;
    assign last_discovered_node    = last_q;
    assign node_discovered_pulse   = disc_q;
endmodule

// File: tb/tb_bfs_simple_engine.sv
// Bench for bfs_simple_engine: word-memory responder with programmable latency,
// output monitors, and a queue-based BFS reference model.
module tb_bfs_simple_engine;
    localparam int NN   = 32;
    localparam int MAXN = 16;
    localparam int ROWW = MAXN + 1;
    localparam int BASE = 256;

    logic        clk = 1'b0;
    logic        rst, start, mem_valid, mem_rd_en;
    logic [31:0] start_node_id, mem_data, mem_addr;
    logic        done, busy, incr_edge_pulse, node_discovered_pulse;
    logic [31:0] nodes_visited_count, edges_scanned_count, current_node_processing;
    logic [31:0] current_level, last_discovered_node;

    always #5 clk = ~clk;

    bfs_simple_engine #(.NUM_NODES(NN), .MAX_NEIGHBORS(MAXN), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .start_node_id(start_node_id),
        .done(done), .busy(busy), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .nodes_visited_count(nodes_visited_count), .edges_scanned_count(edges_scanned_count),
        .incr_edge_pulse(incr_edge_pulse), .current_node_processing(current_node_processing),
        .current_level(current_level), .last_discovered_node(last_discovered_node),
        .node_discovered_pulse(node_discovered_pulse)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_words [NN*ROWW];
    int          mem_lat = 1;

    // Monitor state (written only by the responder process).
    int          rd_total = 0, disc_total = 0, edgep_total = 0, viol_total = 0;
    int          disc_log[$];
    int          resp_cnt = 0;
    logic [31:0] resp_data = '0;
    bit          prev_rd = 1'b0;

    // Snapshots taken at each start.
    int s_rd, s_disc, s_edgep, s_viol, s_ord;

    // Reference model results.
    int m_vis_cnt, m_edges, m_reads;
    int m_level[NN], m_parent[NN];
    bit m_vis[NN];
    int m_order[$];

    // Memory responder and output monitor, sampled on the falling edge.
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = resp_data;
                end
            end
            if (mem_rd_en === 1'b1) begin
                rd_total++;
                if (resp_cnt != 0 || prev_rd) viol_total++;
                if (mem_addr < BASE || mem_addr[1:0] != 2'b00 || ((mem_addr - BASE) >> 2) >= NN*ROWW) begin
                    viol_total++;
                    resp_data = 32'hDEAD_BEEF;
                end else begin
                    resp_data = mem_words[int'((mem_addr - BASE) >> 2)];
                end
                resp_cnt = mem_lat;
            end
            prev_rd = (mem_rd_en === 1'b1);
            if (node_discovered_pulse === 1'b1) begin
                disc_total++;
                disc_log.push_back(int'(last_discovered_node));
            end
            if (incr_edge_pulse === 1'b1) edgep_total++;
        end
    end

    function automatic void model_bfs(input logic [31:0] root);
        int q[$];
        int u;
        logic [31:0] deg, v;
        m_vis_cnt = 0; m_edges = 0; m_reads = 0; m_order = {};
        for (int i = 0; i < NN; i++) begin m_vis[i] = 0; m_level[i] = 0; m_parent[i] = 0; end
        if (root >= NN) return;
        m_vis[root] = 1; m_parent[root] = int'(root); m_vis_cnt = 1;
        m_order.push_back(int'(root)); q.push_back(int'(root));
        while (q.size() > 0) begin
            u = q.pop_front();
            m_reads++;
            deg = mem_words[u*ROWW];
            if (deg > MAXN) deg = MAXN;
            for (int k = 1; k <= int'(deg); k++) begin
                v = mem_words[u*ROWW + k];
                m_edges++; m_reads++;
                if (v < NN && !m_vis[v]) begin
                    m_vis[v] = 1; m_level[v] = m_level[u] + 1; m_parent[v] = u;
                    m_vis_cnt++; m_order.push_back(int'(v)); q.push_back(int'(v));
                end
            end
        end
    endfunction

    function automatic void clear_graph();
        for (int i = 0; i < NN*ROWW; i++) mem_words[i] = '0;
    endfunction

    function automatic void add_edge(input int u, input int v);
        int d;
        d = int'(mem_words[u*ROWW]);
        mem_words[u*ROWW + 1 + d] = v;
        mem_words[u*ROWW] = d + 1;
    endfunction

    task automatic run_bfs(input logic [31:0] root, input int budget, input int restart_at, output int cycles);
        s_rd = rd_total; s_disc = disc_total; s_edgep = edgep_total; s_viol = viol_total; s_ord = disc_log.size();
        start_node_id = root;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_node_id = $urandom;
        cycles = 1;
        while (done !== 1'b1 && cycles < budget) begin
            if (cycles == restart_at) begin start = 1'b1; start_node_id = 32'd7; end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout root=%0d: done=%b after %0d cycles, required 1", root, done, cycles);
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({done, busy, mem_rd_en, incr_edge_pulse, node_discovered_pulse} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 00000", {done, busy, mem_rd_en, incr_edge_pulse, node_discovered_pulse});
        end
        checks++;
        if ((nodes_visited_count | edges_scanned_count | current_node_processing | current_level | last_discovered_node | mem_addr) !== 32'd0) begin
            errors++; $display("FAIL reset_data: OR of data outputs %h, required 0", nodes_visited_count | edges_scanned_count | current_node_processing | current_level | last_discovered_node | mem_addr);
        end
        checks++;
        if (dut.visited_q !== '0) begin errors++; $display("FAIL reset_visited: got %h, required 0", dut.visited_q); end
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_total !== 0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b done=%b reads=%0d, required 0/0/0", busy, done, rd_total);
        end
    endtask

    task automatic test_chain();
        int cyc, nbad;
        int got[$];
        clear_graph(); add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
        mem_lat = 2; model_bfs(0);
        run_bfs(0, 2000, -1, cyc);
        checks++; if (nodes_visited_count !== 4) begin errors++; $display("FAIL chain_visited: got %0d, required 4", nodes_visited_count); end
        checks++; if (edges_scanned_count !== 3) begin errors++; $display("FAIL chain_edges: got %0d, required 3", edges_scanned_count); end
        checks++; if (last_discovered_node !== 3) begin errors++; $display("FAIL chain_last: got %0d, required 3", last_discovered_node); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL chain_status: done=%b busy=%b, required 1/0", done, busy); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.node_info_q[i].level !== i) begin errors++; $display("FAIL chain_level%0d: got %0d, required %0d", i, dut.node_info_q[i].level, i); end
        end
        got = disc_log[s_ord:$];
        nbad = (got.size() != m_order.size());
        foreach (m_order[i]) if (i < got.size() && got[i] != m_order[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL chain_order: %0d mismatches, %0d discoveries, required %0d", nbad, got.size(), m_order.size()); end
        checks++; if (rd_total - s_rd !== m_reads || viol_total != s_viol) begin errors++; $display("FAIL chain_reads: got %0d (viol %0d), required %0d (viol 0)", rd_total - s_rd, viol_total - s_viol, m_reads); end
    endtask

    task automatic test_star();
        int cyc, nbad;
        clear_graph();
        for (int v = 1; v <= 5; v++) add_edge(0, v);
        mem_lat = 1;
        run_bfs(0, 2000, -1, cyc);
        checks++; if (disc_total - s_disc !== 6) begin errors++; $display("FAIL star_pulses: got %0d, required 6", disc_total - s_disc); end
        checks++; if (edges_scanned_count !== 5 || edgep_total - s_edgep !== 5) begin errors++; $display("FAIL star_edges: count %0d pulses %0d, required 5", edges_scanned_count, edgep_total - s_edgep); end
        nbad = 0;
        for (int v = 1; v <= 5; v++) if (dut.node_info_q[v].level !== 1 || dut.node_info_q[v].parent !== 0 || dut.visited_q[v] !== 1'b1) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL star_leaves: %0d leaves wrong, required level 1 parent 0 visited", nbad); end
        checks++; if (nodes_visited_count !== 6) begin errors++; $display("FAIL star_visited: got %0d, required 6", nodes_visited_count); end
    endtask

    task automatic test_cycle();
        int cyc;
        clear_graph(); add_edge(0, 1); add_edge(1, 2); add_edge(1, 1); add_edge(2, 0);
        mem_lat = 3;
        run_bfs(0, 2000, -1, cyc);
        checks++; if (nodes_visited_count !== 3) begin errors++; $display("FAIL cycle_visited: got %0d, required 3", nodes_visited_count); end
        checks++; if (edges_scanned_count !== 4) begin errors++; $display("FAIL cycle_edges: got %0d, required 4", edges_scanned_count); end
        checks++; if (disc_total - s_disc !== 3) begin errors++; $display("FAIL cycle_pulses: got %0d, required 3", disc_total - s_disc); end
        checks++; if (last_discovered_node !== 2) begin errors++; $display("FAIL cycle_last: got %0d, required 2", last_discovered_node); end
    endtask

    task automatic test_out_of_range();
        int cyc;
        run_bfs(40, 50, -1, cyc);
        checks++; if (cyc > 3) begin errors++; $display("FAIL oor_latency: done after %0d cycles, required <= 3", cyc); end
        checks++; if (rd_total - s_rd !== 0) begin errors++; $display("FAIL oor_reads: got %0d, required 0", rd_total - s_rd); end
        checks++; if (nodes_visited_count !== 0 || edges_scanned_count !== 0) begin errors++; $display("FAIL oor_counts: visited %0d edges %0d, required 0/0", nodes_visited_count, edges_scanned_count); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oor_status: done=%b busy=%b, required 1/0", done, busy); end
    endtask

    task automatic test_degree_clamp();
        int cyc;
        clear_graph();
        mem_words[0] = 20;
        // Even slots name nodes 2..16, odd slots name IDs 33..47 beyond the graph.
        for (int k = 1; k <= MAXN; k++) mem_words[k] = (k % 2 == 0) ? k : 32 + k;
        mem_words[MAXN + 1] = 3;   // node 1 degree word: would be read if the clamp failed
        mem_lat = 2; model_bfs(0);
        run_bfs(0, 4000, -1, cyc);
        checks++; if (edges_scanned_count !== 16) begin errors++; $display("FAIL clamp_edges: got %0d, required 16", edges_scanned_count); end
        checks++; if (nodes_visited_count !== 9) begin errors++; $display("FAIL clamp_visited: got %0d, required 9", nodes_visited_count); end
        checks++; if (rd_total - s_rd !== m_reads || viol_total != s_viol) begin errors++; $display("FAIL clamp_reads: got %0d (viol %0d), required %0d (viol 0)", rd_total - s_rd, viol_total - s_viol, m_reads); end
    endtask

    task automatic test_latency_and_restart();
        int cyc;
        logic [31:0] v5, e5, l5;
        clear_graph();
        add_edge(0, 1); add_edge(0, 2); add_edge(0, 3); add_edge(1, 4); add_edge(1, 5);
        add_edge(2, 5); add_edge(2, 6); add_edge(3, 0); add_edge(6, 7);
        model_bfs(0);
        mem_lat = 5;
        run_bfs(0, 4000, 8, cyc);
        v5 = nodes_visited_count; e5 = edges_scanned_count; l5 = last_discovered_node;
        checks++; if (v5 !== m_vis_cnt || e5 !== m_edges) begin errors++; $display("FAIL lat5_counts: visited %0d edges %0d, required %0d/%0d", v5, e5, m_vis_cnt, m_edges); end
        checks++; if (l5 !== m_order[$]) begin errors++; $display("FAIL lat5_last: got %0d, required %0d", l5, m_order[$]); end
        checks++; if (viol_total != s_viol) begin errors++; $display("FAIL lat5_protocol: %0d read violations, required 0", viol_total - s_viol); end
        mem_lat = 1;
        run_bfs(0, 4000, -1, cyc);
        checks++; if (nodes_visited_count !== v5 || edges_scanned_count !== e5 || last_discovered_node !== l5) begin
            errors++; $display("FAIL lat1_vs_lat5: %0d/%0d/%0d, required %0d/%0d/%0d", nodes_visited_count, edges_scanned_count, last_discovered_node, v5, e5, l5);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, n, rd0, nbad;
        clear_graph();
        add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3); add_edge(3, 4);
        mem_lat = 2; model_bfs(0);
        s_rd = rd_total;
        start_node_id = 0; start = 1'b1; @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (rd_total - s_rd < 3 && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (rd_total - s_rd < 3) begin errors++; $display("FAIL midscan_progress: %0d reads, required >= 3", rd_total - s_rd); end
        rst = 1'b1; @(posedge clk); #1;
        checks++;
        if ({done, busy, mem_rd_en, incr_edge_pulse, node_discovered_pulse} !== 5'b0 ||
            (nodes_visited_count | edges_scanned_count | current_node_processing | current_level | last_discovered_node | mem_addr) !== 32'd0) begin
            errors++; $display("FAIL midscan_reset_outputs: ctrl %b data-or %h, required 0/0", {done, busy, mem_rd_en, incr_edge_pulse, node_discovered_pulse},
                nodes_visited_count | edges_scanned_count | current_node_processing | current_level | last_discovered_node | mem_addr);
        end
        rst = 1'b0;
        rd0 = rd_total;
        repeat (10) @(posedge clk); #1;
        checks++; if (rd_total !== rd0) begin errors++; $display("FAIL midscan_quiet: %0d reads after reset, required 0", rd_total - rd0); end
        run_bfs(0, 2000, -1, cyc);
        nbad = 0;
        for (int i = 0; i < NN; i++)
            if (dut.visited_q[i] !== m_vis[i] || (m_vis[i] && (dut.node_info_q[i].level !== m_level[i] || dut.node_info_q[i].parent !== m_parent[i]))) nbad++;
        checks++; if (nbad != 0 || nodes_visited_count !== m_vis_cnt) begin errors++; $display("FAIL midscan_restart: %0d nodes wrong, visited %0d, required %0d", nbad, nodes_visited_count, m_vis_cnt); end
    endtask

    task automatic test_random();
        int cyc, nbad;
        logic [31:0] root;
        int got[$];
        for (int it = 0; it < 6; it++) begin
            for (int n = 0; n < NN; n++) begin
                for (int k = 1; k <= MAXN; k++) mem_words[n*ROWW + k] = $urandom_range(0, 39);
                mem_words[n*ROWW] = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 40) : $urandom_range(0, 4);
            end
            root = $urandom_range(0, NN - 1);
            mem_lat = $urandom_range(1, 4);
            model_bfs(root);
            run_bfs(root, 20000, 5, cyc);
            checks++; if (nodes_visited_count !== m_vis_cnt || edges_scanned_count !== m_edges) begin
                errors++; $display("FAIL rand%0d_counts: visited %0d edges %0d, required %0d/%0d", it, nodes_visited_count, edges_scanned_count, m_vis_cnt, m_edges);
            end
            checks++; if (disc_total - s_disc !== m_vis_cnt || edgep_total - s_edgep !== m_edges) begin
                errors++; $display("FAIL rand%0d_pulses: disc %0d edge %0d, required %0d/%0d", it, disc_total - s_disc, edgep_total - s_edgep, m_vis_cnt, m_edges);
            end
            checks++; if (rd_total - s_rd !== m_reads || viol_total != s_viol) begin
                errors++; $display("FAIL rand%0d_reads: got %0d (viol %0d), required %0d (viol 0)", it, rd_total - s_rd, viol_total - s_viol, m_reads);
            end
            got = disc_log[s_ord:$];
            nbad = (got.size() != m_order.size());
            foreach (m_order[i]) if (i < got.size() && got[i] != m_order[i]) nbad++;
            for (int i = 0; i < NN; i++)
                if (dut.visited_q[i] !== m_vis[i] || (m_vis[i] && (dut.node_info_q[i].level !== m_level[i] || dut.node_info_q[i].parent !== m_parent[i]))) nbad++;
            checks++; if (nbad != 0) begin errors++; $display("FAIL rand%0d_tree: %0d order/level/parent mismatches, required 0", it, nbad); end
            checks++; if (last_discovered_node !== m_order[$]) begin errors++; $display("FAIL rand%0d_last: got %0d, required %0d", it, last_discovered_node, m_order[$]); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_node_id = '0;
        clear_graph();
        test_reset();
        test_chain();
        test_star();
        test_cycle();
        test_out_of_range();
        test_degree_clamp();
        test_latency_and_restart();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
